// File: rtl/if_else_emitter.sv
// Serialises one "if x<op> N p<=N else p<=N;" statement as paced 7-bit ASCII characters.
// Build option: define NEWLINE_TERM_EN to emit a trailing 0x0A after the ';'.
module if_else_emitter #(
  parameter int CHAR_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  comparator,
  input  logic [31:0] valc,
  input  logic [31:0] const1,
  input  logic [31:0] const2,
  output logic [6:0]  ascii_char,
  output logic        char_valid,
  output logic        busy,
  output logic        done,
  output logic        error_flag,
  output logic [2:0]  state_dbg
);

  // Stream contract: char_valid is a one-cycle strobe with no back-pressure; ascii_char is
  // meaningful only while it is high and then holds until the next strobe.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TEXT, S_CONV, S_DIGIT, S_GAP, S_FIN, S_ERR
  } state_t;

  // Template slots: each number occupies a single slot and is expanded by CONV/DIGIT.
  localparam logic [4:0] POS_OP0  = 5'd4;
  localparam logic [4:0] POS_NUM0 = 5'd7;
  localparam logic [4:0] POS_NUM1 = 5'd12;
  localparam logic [4:0] POS_NUM2 = 5'd22;
`ifdef NEWLINE_TERM_EN
  localparam logic [4:0] POS_END  = 5'd25;
`else
  localparam logic [4:0] POS_END  = 5'd24;
`endif
  localparam logic [3:0] GAP_INIT = 4'(CHAR_GAP - 1);

  state_t      state, ret_state;
  logic [2:0]  cmp_q;
  logic [31:0] valc_q, const1_q, const2_q;
  logic [4:0]  pos;
  logic [3:0]  gap_cnt;
  logic [31:0] rem;
  logic [3:0]  pidx, digit;
  logic        seen;

  logic [6:0]  lit_char;
  logic [4:0]  nxt_pos;
  logic        is_num, two_char_op;
  logic [31:0] num_sel, pow;

  assign state_dbg   = state;
  assign two_char_op = (cmp_q != 3'd2) && (cmp_q != 3'd3);
  assign nxt_pos     = (pos == POS_OP0 && !two_char_op) ? 5'd6 : pos + 5'd1;
  assign is_num      = (pos == POS_NUM0) || (pos == POS_NUM1) || (pos == POS_NUM2);

  always_comb begin
    lit_char = 7'h20;
    case (pos)
      5'd0:         lit_char = 7'h69;
      5'd1:         lit_char = 7'h66;
      5'd3:         lit_char = 7'h78;
      5'd4: begin
        case (cmp_q)
          3'd0:       lit_char = 7'h3D;
          3'd1:       lit_char = 7'h21;
          3'd2, 3'd4: lit_char = 7'h3C;
          default:    lit_char = 7'h3E;
        endcase
      end
      5'd5, 5'd11, 5'd21: lit_char = 7'h3D;
      5'd9, 5'd19:  lit_char = 7'h70;
      5'd10, 5'd20: lit_char = 7'h3C;
      5'd14, 5'd17: lit_char = 7'h65;
      5'd15:        lit_char = 7'h6C;
      5'd16:        lit_char = 7'h73;
      5'd23:        lit_char = 7'h3B;
      5'd24:        lit_char = 7'h0A;
      default:      lit_char = 7'h20;
    endcase
  end

  always_comb begin
    num_sel = const2_q;
    if (pos == POS_NUM0)      num_sel = valc_q;
    else if (pos == POS_NUM1) num_sel = const1_q;
  end

  always_comb begin
    pow = 32'd1;
    case (pidx)
      4'd1:    pow = 32'd10;
      4'd2:    pow = 32'd100;
      4'd3:    pow = 32'd1000;
      4'd4:    pow = 32'd10000;
      4'd5:    pow = 32'd100000;
      4'd6:    pow = 32'd1000000;
      4'd7:    pow = 32'd10000000;
      4'd8:    pow = 32'd100000000;
      4'd9:    pow = 32'd1000000000;
      default: pow = 32'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      cmp_q      <= '0;
      valc_q     <= '0;
      const1_q   <= '0;
      const2_q   <= '0;
      pos        <= '0;
      gap_cnt    <= '0;
      rem        <= '0;
      pidx       <= '0;
      digit      <= '0;
      seen       <= 1'b0;
      ascii_char <= '0;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cmp_q      <= comparator;
            valc_q     <= valc;
            const1_q   <= const1;
            const2_q   <= const2;
            pos        <= '0;
            busy       <= 1'b1;
            error_flag <= 1'b0;
            state      <= (comparator > 3'd5) ? S_ERR : S_LOAD;
          end
        end
        // LOAD shares TEXT's emit path so 'i' leaves one cycle after the accepted start.
        S_LOAD, S_TEXT: begin
          if (is_num) begin
            rem   <= num_sel;
            pidx  <= 4'd9;
            digit <= '0;
            seen  <= 1'b0;
            state <= S_CONV;
          end else begin
            ascii_char <= lit_char;
            char_valid <= 1'b1;
            pos        <= nxt_pos;
            ret_state  <= (nxt_pos == POS_END) ? S_FIN : S_TEXT;
            gap_cnt    <= GAP_INIT;
            state      <= S_GAP;
          end
        end
        S_CONV: begin
          if (rem >= pow) begin
            rem   <= rem - pow;
            digit <= digit + 4'd1;
          end else if (digit == 4'd0 && !seen && pidx != 4'd0) begin
            pidx <= pidx - 4'd1;
          end else begin
            state <= S_DIGIT;
          end
        end
        S_DIGIT: begin
          ascii_char <= 7'h30 + {3'b000, digit};
          char_valid <= 1'b1;
          seen       <= 1'b1;
          digit      <= '0;
          gap_cnt    <= GAP_INIT;
          state      <= S_GAP;
          if (pidx == 4'd0) begin
            pos       <= pos + 5'd1;
            ret_state <= S_TEXT;
          end else begin
            pidx      <= pidx - 4'd1;
            ret_state <= S_CONV;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= ret_state;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          error_flag <= 1'b1;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_else_emitter.sv
// Bench for if_else_emitter: two instances (CHAR_GAP 1 and 3) checked against a text model.
module tb_if_else_emitter;

  localparam int GAP_A = 1;
  localparam int GAP_B = 3;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [2:0]  comparator = '0;
  logic [31:0] valc = '0;
  logic [31:0] const1 = '0;
  logic [31:0] const2 = '0;

  logic [6:0]  ch [2];
  logic        cv [2];
  logic        bz [2];
  logic        dn [2];
  logic        ef [2];
  logic [2:0]  sd [2];

  always #5 clk = ~clk;

  if_else_emitter #(.CHAR_GAP(GAP_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .comparator(comparator),
    .valc(valc), .const1(const1), .const2(const2),
    .ascii_char(ch[0]), .char_valid(cv[0]), .busy(bz[0]), .done(dn[0]),
    .error_flag(ef[0]), .state_dbg(sd[0])
  );

  if_else_emitter #(.CHAR_GAP(GAP_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .comparator(comparator),
    .valc(valc), .const1(const1), .const2(const2),
    .ascii_char(ch[1]), .char_valid(cv[1]), .busy(bz[1]), .done(dn[1]),
    .error_flag(ef[1]), .state_dbg(sd[1])
  );

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [6:0]  exp_q0[$];
  logic [6:0]  exp_q1[$];
  logic [6:0]  last_ch [2];
  int          since [2];
  int          pulses [2];
  string       got [2];
  logic [6:0]  e_ch;
  bit          have;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, req);
    end
  endtask

  function automatic string nl();
`ifdef NEWLINE_TERM_EN
    return "\n";
`else
    return "";
`endif
  endfunction

  // Model: the statement text the receiver must see, built directly from the operands.
  function automatic string model_text(input logic [2:0] cmp, input logic [31:0] v,
                                       input logic [31:0] c1, input logic [31:0] c2);
    string op;
    case (cmp)
      3'd0:    op = "==";
      3'd1:    op = "!=";
      3'd2:    op = "<";
      3'd3:    op = ">";
      3'd4:    op = "<=";
      default: op = ">=";
    endcase
    return $sformatf("if x%s %0d p<=%0d else p<=%0d;%s", op, v, c1, c2, nl());
  endfunction

  // Receiver model: parse the captured text and evaluate p for a given x.
  function automatic longint loop_eval(input string s, input longint x);
    string  op = "";
    longint n [3];
    int     ni = 0;
    longint acc = 0;
    bit     in_num = 0;
    bit     c;
    int     k = 4;
    byte    b;
    n[0] = 0; n[1] = 0; n[2] = 0;
    while (k < s.len() && s[k] != 8'h20) begin
      op = {op, s.substr(k, k)};
      k++;
    end
    for (int j = k; j < s.len(); j++) begin
      b = s[j];
      if (b >= 8'h30 && b <= 8'h39) begin
        acc = acc * 10 + longint'(b - 8'h30);
        in_num = 1;
      end else if (in_num) begin
        if (ni < 3) n[ni] = acc;
        ni++;
        acc = 0;
        in_num = 0;
      end
    end
    if      (op == "==") c = (x == n[0]);
    else if (op == "!=") c = (x != n[0]);
    else if (op == "<")  c = (x <  n[0]);
    else if (op == ">")  c = (x >  n[0]);
    else if (op == "<=") c = (x <= n[0]);
    else                 c = (x >= n[0]);
    return c ? n[1] : n[2];
  endfunction

  // Compare process: every cycle, both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk(cv[i] == 0 && bz[i] == 0 && dn[i] == 0 && ch[i] == 0 && ef[i] == 0,
            "reset_outputs", {cv[i], bz[i], dn[i], ef[i]}, 0);
        last_ch[i] = '0;
        since[i]   = 99;
      end else if (cv[i]) begin
        have = 1'b1;
        e_ch = '0;
        if (i == 0) begin
          if (exp_q0.size() > 0) e_ch = exp_q0.pop_front(); else have = 1'b0;
        end else begin
          if (exp_q1.size() > 0) e_ch = exp_q1.pop_front(); else have = 1'b0;
        end
        chk(have, "unexpected_pulse", ch[i], 0);
        if (have) chk(ch[i] == e_ch, "char", ch[i], e_ch);
        chk(since[i] >= ((i == 0) ? GAP_A : GAP_B), "min_gap", since[i], (i == 0) ? GAP_A : GAP_B);
        if (pulses[i] > 0 && !(ch[i] >= 7'h30 && ch[i] <= 7'h39))
          chk(since[i] == ((i == 0) ? GAP_A : GAP_B), "literal_spacing", since[i],
              (i == 0) ? GAP_A : GAP_B);
        got[i]     = $sformatf("%s%c", got[i], ch[i]);
        pulses[i]  = pulses[i] + 1;
        since[i]   = 0;
        last_ch[i] = ch[i];
      end else begin
        if (dn[i] && pulses[i] > 0)
          chk(since[i] == ((i == 0) ? GAP_A : GAP_B), "done_spacing", since[i],
              (i == 0) ? GAP_A : GAP_B);
        if (bz[i]) chk(ch[i] == last_ch[i], "char_hold", ch[i], last_ch[i]);
        since[i] = since[i] + 1;
      end
    end
  end

  // Driver: one statement on one instance, with optional start pulses while busy.
  task automatic run_stmt(input int inst, input logic [2:0] cmp, input logic [31:0] v,
                          input logic [31:0] c1, input logic [31:0] c2,
                          input string lit, input bit mid_start);
    string exp_s;
    bit    is_err;
    bit    done_ok;
    byte   b;
    is_err = (cmp > 3'd5);
    exp_s  = is_err ? "" : model_text(cmp, v, c1, c2);
    if (lit != "") chk_s("model_pin", exp_s, {lit, nl()});
    for (int k = 0; k < exp_s.len(); k++) begin
      b = exp_s[k];
      if (inst == 0) exp_q0.push_back(b[6:0]); else exp_q1.push_back(b[6:0]);
    end
    pulses[inst] = 0;
    got[inst]    = "";
    @(posedge clk); #1;
    comparator = cmp; valc = v; const1 = c1; const2 = c2;
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    chk(bz[inst] == 1, "busy_after_start", bz[inst], 1);
    if (!is_err) begin
      chk(ef[inst] == 0, "error_clears_on_start", ef[inst], 0);
      @(posedge clk); #1;
      chk(cv[inst] == 1 && ch[inst] == 7'h69, "first_char_i", {cv[inst], ch[inst]}, {1'b1, 7'h69});
    end
    if (mid_start) begin
      repeat (10) @(posedge clk);
      #1;
      comparator = 3'd0; valc = 32'd999; const1 = 32'd998; const2 = 32'd997;
      if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start_a = 1'b0; start_b = 1'b0;
    end
    done_ok = 1'b0;
    for (int k = 0; k < 4000 && !done_ok; k++) begin
      @(negedge clk);
      if (dn[inst]) done_ok = 1'b1;
    end
    chk(done_ok, "done_timeout", done_ok, 1);
    chk(ef[inst] == is_err, "error_flag", ef[inst], is_err);
    chk((inst == 0 ? exp_q0.size() : exp_q1.size()) == 0, "chars_missing",
        inst == 0 ? exp_q0.size() : exp_q1.size(), 0);
    chk(pulses[inst] == exp_s.len(), "pulse_count", pulses[inst], exp_s.len());
    chk_s("stream_text", got[inst], exp_s);
    @(negedge clk);
    chk(dn[inst] == 0 && bz[inst] == 0, "done_one_cycle", {dn[inst], bz[inst]}, 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bit ok;
    string exp_s;
    byte b;
    since[0] = 99; since[1] = 99;
    pulses[0] = 0; pulses[1] = 0;
    last_ch[0] = '0; last_ch[1] = '0;
    got[0] = ""; got[1] = "";

    repeat (3) @(posedge clk);
    #1;
    chk(cv[0] == 0 && bz[0] == 0 && ch[0] == 0, "reset_state_a", {cv[0], bz[0], ch[0]}, 0);
    rst_n = 1'b1;

    run_stmt(0, 3'd4, 32'd5, 32'd1, 32'd2, "if x<= 5 p<=1 else p<=2;", 1'b0);
    chk(got[0].len() == 24 + nl().len(), "len_24", got[0].len(), 24 + nl().len());

    run_stmt(0, 3'd2, 32'd0, 32'hFFFF_FFFF, 32'd10, "if x< 0 p<=4294967295 else p<=10;", 1'b0);

    run_stmt(0, 3'd7, 32'd1, 32'd2, 32'd3, "", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk(ef[0] == 1, "error_flag_holds", ef[0], 1);
    run_stmt(0, 3'd0, 32'd3, 32'd4, 32'd5, "if x== 3 p<=4 else p<=5;", 1'b0);

    run_stmt(0, 3'd1, 32'd123, 32'd7, 32'd8, "if x!= 123 p<=7 else p<=8;", 1'b1);

    run_stmt(0, 3'd6, 32'd1, 32'd1, 32'd1, "", 1'b0);
    run_stmt(0, 3'd5, 32'd1000000000, 32'd4000000009, 32'd100, "", 1'b0);

    // Asynchronous reset in the middle of a statement
    exp_s = model_text(3'd1, 32'd4, 32'd43, 32'd44);
    for (int k = 0; k < exp_s.len(); k++) begin
      b = exp_s[k];
      exp_q0.push_back(b[6:0]);
    end
    pulses[0] = 0;
    got[0] = "";
    @(posedge clk); #1;
    comparator = 3'd1; valc = 32'd4; const1 = 32'd43; const2 = 32'd44;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk); #1;
      if (pulses[0] >= 7) ok = 1'b1;
    end
    chk(ok, "reach_7th_char", pulses[0], 7);
    chk(cv[0] == 1, "7th_pulse_live", cv[0], 1);
    exp_q0.delete();
    rst_n = 1'b0;
    #1;
    chk(cv[0] == 0 && bz[0] == 0 && ch[0] == 0, "async_reset", {cv[0], bz[0], ch[0]}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_stmt(0, 3'd5, 32'd77, 32'd88, 32'd99, "if x>= 77 p<=88 else p<=99;", 1'b0);

    // Wider gap, loopback through the receiver model
    run_stmt(1, 3'd3, 32'd6, 32'd11, 32'd22, "if x> 6 p<=11 else p<=22;", 1'b0);
    chk(loop_eval(got[1], 7) == 11, "loopback_p", loop_eval(got[1], 7), 11);
    run_stmt(1, 3'd4, 32'd90, 32'd0, 32'd305, "if x<= 90 p<=0 else p<=305;", 1'b0);
    chk(loop_eval(got[1], 7) == 0, "loopback_p2", loop_eval(got[1], 7), 0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
